// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared CPU package: reset vector, fetch FSM state encoding
//                and word-alignment helpers used by the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Data path width of the core.
    localparam int unsigned c_xlen = 32;

    // Default first fetch address after reset.
    localparam logic [31:0] c_reset_pc = 32'h0000_3000;

    // Fetch stage states; at most one instruction-memory request outstanding.
    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,   // request on the bus, waiting for grant
        FS_WAIT  = 2'd1,   // granted, waiting for read data
        FS_HOLD  = 2'd2,   // instruction held for decode
        FS_DROP  = 2'd3    // flushed while a response is still in flight
    } fetch_state_e;

    // Force an address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // True when an address is not word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_if
//  Description : Instruction-memory request/response bus between the fetch
//                stage (master) and the instruction memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_if;
    import mips_pkg::*;

    logic              req;     // request valid
    logic [c_xlen-1:0] addr;    // request word address
    logic              gnt;     // request accepted this cycle
    logic              rvalid;  // read data valid
    logic [c_xlen-1:0] rdata;   // instruction word

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface
`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch
//  Description : Instruction fetch stage. Issues one instruction-memory
//                request at a time, holds the returned word for decode, and
//                advances the PC from npc on handoff or from redirect_pc on a
//                flush. Responses already in flight at a flush are dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       npc,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    pc_fetch_if.master        imem,
    output logic              if_valid,
    input  logic              id_ready,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_pc4,
    output logic              addr_err,
    output logic [31:0]       fetch_cnt
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic [31:0]  r_pc;
    logic [31:0]  r_if_instr;
    logic [31:0]  r_if_pc;
    logic [31:0]  r_if_pc4;
    logic [31:0]  r_fetch_cnt;
    logic         r_addr_err;

    logic         w_imem_req;
    logic         w_if_valid;
    logic         w_latch;
    logic         w_handoff;
    logic         w_load;
    logic [31:0]  w_load_addr;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_cnt_next;

    // Next-state and per-state outputs of the fetch FSM.
    always_comb begin
        w_state_next = r_state;
        w_imem_req   = 1'b0;
        w_if_valid   = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            FS_FETCH: begin
                w_imem_req = 1'b1;
                // A stray rvalid here has no matching request and is ignored.
                if (redirect) begin
                    // A granted request still owes a response that must be dropped.
                    w_state_next = imem.gnt ? FS_DROP : FS_FETCH;
                end else if (imem.gnt) begin
                    w_state_next = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (redirect) begin
                    w_state_next = imem.rvalid ? FS_FETCH : FS_DROP;
                end else if (imem.rvalid) begin
                    w_latch      = 1'b1;
                    w_state_next = FS_HOLD;
                end
            end
            FS_HOLD: begin
                w_if_valid = !redirect;
                if (redirect || id_ready) begin
                    w_state_next = FS_FETCH;
                end
            end
            FS_DROP: begin
                if (imem.rvalid) begin
                    w_state_next = FS_FETCH;
                end
            end
            default: begin
                w_state_next = FS_FETCH;
            end
        endcase
    end

    // PC source selection: a redirect always wins over a decode handoff.
    always_comb begin
        w_handoff   = w_if_valid && id_ready;
        w_load      = 1'b0;
        w_load_addr = r_pc;
        if (redirect) begin
            w_load      = 1'b1;
            w_load_addr = redirect_pc;
        end else if (w_handoff) begin
            w_load      = 1'b1;
            w_load_addr = npc;
        end
        w_pc_next  = w_load ? word_align(w_load_addr) : r_pc;
        w_cnt_next = w_handoff ? (r_fetch_cnt + 32'd1) : r_fetch_cnt;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FS_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC, sticky alignment error and handoff counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_addr_err  <= 1'b0;
            r_fetch_cnt <= 32'd0;
        end else begin
            r_pc        <= w_pc_next;
            r_addr_err  <= r_addr_err | (w_load & is_misaligned(w_load_addr));
            // Written every cycle so the counter always reflects its own
            // current value plus any handoff.
            r_fetch_cnt <= w_cnt_next;
        end
    end

    // Capture the returned instruction with its address; held until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_instr <= 32'd0;
            r_if_pc    <= RESET_PC;
            r_if_pc4   <= RESET_PC + 32'd4;
        end else if (w_latch) begin
            r_if_instr <= imem.rdata;
            r_if_pc    <= r_pc;
            r_if_pc4   <= r_pc + 32'd4;
        end
    end

    // The request is held low for the whole time reset is asserted.
    assign imem.req  = w_imem_req & rst_n;
    assign imem.addr = r_pc;

    assign if_valid  = w_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;
    assign if_pc4    = r_if_pc4;
    assign addr_err  = r_addr_err;
    assign fetch_cnt = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch
//  Description : Self-checking bench for pc_fetch: table of complete fetch
//                transactions plus directed redirect, wrap and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch;

    typedef struct {
        int unsigned gnt_wait;   // cycles before gnt
        int unsigned rsp_wait;   // extra WAIT cycles before rvalid
        int unsigned hold;       // cycles of id_ready=0 in HOLD
        logic [31:0] rdata;
        logic [31:0] npc;
        logic [31:0] exp_addr;   // request address / expected if_pc
        logic [31:0] exp_pc4;
        logic [31:0] exp_cnt;    // fetch_cnt after the handoff
        logic        exp_err;    // addr_err after the handoff
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] npc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        addr_err;
    logic [31:0] fetch_cnt;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs[8];
    vec_t vg;

    pc_fetch_if imem();

    pc_fetch #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .npc         (npc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .if_valid    (if_valid),
        .id_ready    (id_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4),
        .addr_err    (addr_err),
        .fetch_cnt   (fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int unsigned gw, input int unsigned rw,
                                input int unsigned hd, input logic [31:0] rd,
                                input logic [31:0] np, input logic [31:0] ea,
                                input logic [31:0] ep, input logic [31:0] ec,
                                input logic ee);
        vec_t v;
        v.gnt_wait = gw; v.rsp_wait = rw; v.hold = hd;
        v.rdata = rd; v.npc = np; v.exp_addr = ea; v.exp_pc4 = ep;
        v.exp_cnt = ec; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // One complete transaction from FETCH through handoff, starting at a negedge in FETCH.
    task automatic do_fetch(input string tag, input vec_t v);
        chkb({tag, "_req"}, imem.req, 1'b1);
        chk({tag, "_addr"}, imem.addr, v.exp_addr);
        repeat (v.gnt_wait) @(negedge clk);
        chk({tag, "_addr_held"}, imem.addr, v.exp_addr);
        imem.gnt = 1'b1;
        @(negedge clk);
        imem.gnt = 1'b0;
        chkb({tag, "_req_wait"}, imem.req, 1'b0);
        repeat (v.rsp_wait) @(negedge clk);
        imem.rvalid = 1'b1;
        imem.rdata  = v.rdata;
        @(negedge clk);
        imem.rvalid = 1'b0;
        imem.rdata  = 32'd0;
        chkb({tag, "_valid"}, if_valid, 1'b1);
        chk({tag, "_instr"}, if_instr, v.rdata);
        chk({tag, "_if_pc"}, if_pc, v.exp_addr);
        chk({tag, "_if_pc4"}, if_pc4, v.exp_pc4);
        npc = v.npc;
        repeat (v.hold) @(negedge clk);
        if (v.hold != 0) begin
            chkb({tag, "_valid_stall"}, if_valid, 1'b1);
            chk({tag, "_instr_stall"}, if_instr, v.rdata);
            chkb({tag, "_req_stall"}, imem.req, 1'b0);
        end
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        chk({tag, "_cnt"}, fetch_cnt, v.exp_cnt);
        chkb({tag, "_err"}, addr_err, v.exp_err);
        chkb({tag, "_req_next"}, imem.req, 1'b1);
        chkb({tag, "_valid_next"}, if_valid, 1'b0);
    endtask

    initial begin
        //                gw rw hd rdata          npc            addr           pc4            cnt  err
        vecs[0] = mk(0, 0, 0, 32'h2408_0005, 32'h0000_3004, 32'h0000_3000, 32'h0000_3004, 32'd1, 1'b0);
        vecs[1] = mk(2, 0, 5, 32'h8C09_0000, 32'h0000_3010, 32'h0000_3004, 32'h0000_3008, 32'd2, 1'b0);
        vecs[2] = mk(0, 3, 1, 32'h2409_000A, 32'h0000_3014, 32'h0000_3010, 32'h0000_3014, 32'd3, 1'b0);
        vecs[3] = mk(1, 0, 0, 32'h1234_5678, 32'hFFFF_FFFC, 32'h0000_3014, 32'h0000_3018, 32'd4, 1'b0);
        vecs[4] = mk(0, 0, 0, 32'hDEAD_BEEF, 32'h0000_3020, 32'hFFFF_FFFC, 32'h0000_0000, 32'd5, 1'b0);
        vecs[5] = mk(0, 2, 0, 32'hCAFE_0001, 32'h0000_3006, 32'h0000_3020, 32'h0000_3024, 32'd6, 1'b1);
        vecs[6] = mk(0, 0, 0, 32'h0000_0020, 32'h0000_3008, 32'h0000_3004, 32'h0000_3008, 32'd7, 1'b1);
        vecs[7] = mk(0, 0, 2, 32'h1111_2222, 32'h0000_3100, 32'h0000_3008, 32'h0000_300C, 32'd8, 1'b1);

        rst_n = 1'b0; npc = 32'd0; redirect = 1'b0; redirect_pc = 32'd0; id_ready = 1'b0;
        imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'd0;

        // Reset values while rst_n is held low.
        @(negedge clk);
        @(negedge clk);
        chkb("rst_req", imem.req, 1'b0);
        chkb("rst_valid", if_valid, 1'b0);
        chk("rst_addr", imem.addr, 32'h0000_3000);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'h0000_3000);
        chk("rst_if_pc4", if_pc4, 32'h0000_3004);
        chk("rst_cnt", fetch_cnt, 32'd0);
        chkb("rst_err", addr_err, 1'b0);
        rst_n = 1'b1;
        #1;
        chkb("rst_rel_req", imem.req, 1'b1);

        for (int i = 0; i < 8; i++) begin
            do_fetch($sformatf("v%0d", i), vecs[i]);
        end

        // Stray rvalid in FETCH is ignored.
        imem.rvalid = 1'b1; imem.rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        imem.rvalid = 1'b0; imem.rdata = 32'd0;
        chkb("stray_req", imem.req, 1'b1);
        chk("stray_addr", imem.addr, 32'h0000_3100);
        chkb("stray_valid", if_valid, 1'b0);
        chk("stray_instr", if_instr, 32'h1111_2222);

        // Redirect in WAIT, response three cycles later is dropped.
        imem.gnt = 1'b1;
        @(negedge clk);
        imem.gnt = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h0000_4180;
        @(negedge clk);
        redirect = 1'b0;
        chkb("rdw_req_drop", imem.req, 1'b0);
        repeat (2) @(negedge clk);
        chkb("rdw_valid_drop", if_valid, 1'b0);
        imem.rvalid = 1'b1; imem.rdata = 32'h0BAD_0001;
        @(negedge clk);
        imem.rvalid = 1'b0; imem.rdata = 32'd0;
        chkb("rdw_valid", if_valid, 1'b0);
        chkb("rdw_req", imem.req, 1'b1);
        chk("rdw_addr", imem.addr, 32'h0000_4180);
        chk("rdw_instr", if_instr, 32'h1111_2222);
        chk("rdw_cnt", fetch_cnt, 32'd8);

        // Redirect coincident with rvalid in WAIT.
        imem.gnt = 1'b1;
        @(negedge clk);
        imem.gnt = 1'b0;
        imem.rvalid = 1'b1; imem.rdata = 32'h0BAD_0002;
        redirect = 1'b1; redirect_pc = 32'h0000_5000;
        @(negedge clk);
        imem.rvalid = 1'b0; imem.rdata = 32'd0; redirect = 1'b0;
        chkb("rdc_valid", if_valid, 1'b0);
        chkb("rdc_req", imem.req, 1'b1);
        chk("rdc_addr", imem.addr, 32'h0000_5000);
        chk("rdc_instr", if_instr, 32'h1111_2222);

        // Redirect in FETCH with gnt, then again in DROP.
        imem.gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_5100;
        @(negedge clk);
        imem.gnt = 1'b0;
        redirect_pc = 32'h0000_5200;
        chkb("rdf_req_drop", imem.req, 1'b0);
        @(negedge clk);
        redirect = 1'b0;
        chkb("rdd_req_drop", imem.req, 1'b0);
        imem.rvalid = 1'b1; imem.rdata = 32'h0BAD_0003;
        @(negedge clk);
        imem.rvalid = 1'b0; imem.rdata = 32'd0;
        chkb("rdd_req", imem.req, 1'b1);
        chk("rdd_addr", imem.addr, 32'h0000_5200);
        chkb("rdd_valid", if_valid, 1'b0);

        // Redirect in HOLD beats a simultaneous handoff.
        imem.gnt = 1'b1;
        @(negedge clk);
        imem.gnt = 1'b0;
        imem.rvalid = 1'b1; imem.rdata = 32'h3C01_1234;
        @(negedge clk);
        imem.rvalid = 1'b0; imem.rdata = 32'd0;
        chkb("rdh_valid", if_valid, 1'b1);
        chk("rdh_if_pc", if_pc, 32'h0000_5200);
        id_ready = 1'b1; npc = 32'h0000_7000;
        redirect = 1'b1; redirect_pc = 32'h0000_6000;
        #1;
        chkb("rdh_valid_masked", if_valid, 1'b0);
        @(negedge clk);
        id_ready = 1'b0; redirect = 1'b0;
        chk("rdh_addr", imem.addr, 32'h0000_6000);
        chk("rdh_cnt", fetch_cnt, 32'd8);

        // Counter wrap: preload all-ones while in HOLD, then one handoff.
        imem.gnt = 1'b1;
        @(negedge clk);
        imem.gnt = 1'b0;
        imem.rvalid = 1'b1; imem.rdata = 32'h0000_000C;
        @(negedge clk);
        imem.rvalid = 1'b0; imem.rdata = 32'd0;
        force dut.r_fetch_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_fetch_cnt;
        chk("wrap_pre", fetch_cnt, 32'hFFFF_FFFF);
        chk("wrap_if_pc4", if_pc4, 32'h0000_6004);
        npc = 32'h0000_3040; id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        chk("wrap_cnt", fetch_cnt, 32'd0);
        chk("wrap_addr", imem.addr, 32'h0000_3040);

        // Reset asserted in the middle of WAIT.
        vg = mk(0, 0, 0, 32'h2402_0001, 32'h0000_3044, 32'h0000_3040, 32'h0000_3044, 32'd1, 1'b1);
        do_fetch("pre_rst", vg);
        imem.gnt = 1'b1;
        @(negedge clk);
        imem.gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chkb("arst_req", imem.req, 1'b0);
        chkb("arst_valid", if_valid, 1'b0);
        chk("arst_addr", imem.addr, 32'h0000_3000);
        chk("arst_instr", if_instr, 32'd0);
        chk("arst_if_pc", if_pc, 32'h0000_3000);
        chk("arst_if_pc4", if_pc4, 32'h0000_3004);
        chk("arst_cnt", fetch_cnt, 32'd0);
        chkb("arst_err", addr_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        imem.rvalid = 1'b1; imem.rdata = 32'h0BAD_0004;
        @(negedge clk);
        imem.rvalid = 1'b0; imem.rdata = 32'd0;
        chkb("late_rsp_req", imem.req, 1'b1);
        chk("late_rsp_addr", imem.addr, 32'h0000_3000);
        chkb("late_rsp_valid", if_valid, 1'b0);
        chk("late_rsp_instr", if_instr, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
